hamming_7_4_serial_encoder: RTL
===============================

HAMMING_7_4_SERIAL_ENCODER -- requirements
Module: hamming_7_4_serial_encoder

Interface
REQ-001 SHALL have parameter IDLE_BITS, default 1, giving the number of idle cycles (ser_valid low) between consecutive frames; legal range 0..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge triggered.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port in_data, input, 4, information nibble d[3:0], carried as codeword bits [6:3].
REQ-005 SHALL have port in_valid, input, 1, in_data valid.
REQ-006 SHALL have port in_ready, output, 1, high when the block can accept a nibble this cycle.
REQ-007 SHALL have port ser_out, output, 1, serial codeword bit, MSB (bit 6) first.
REQ-008 SHALL have port ser_valid, output, 1, ser_out carries a codeword bit this cycle.
REQ-009 SHALL have port frame_start, output, 1, one-cycle pulse coincident with bit 6 of each frame.
REQ-010 SHALL have port code_out, output, 7, parallel copy of the frame currently being shifted, stable for the whole frame.
REQ-011 SHALL have port busy, output, 1, high when a frame is shifting, a gap is running, or the holding buffer is full.

Function
REQ-012 SHALL encode c[6:3]=d[3:0], c[2]=c6^c5^c4, c[1]=c6^c5^c3, c[0]=c6^c4^c3; this is the layout the team's (7,4) corrector consumes.
REQ-013 SHALL accept a nibble on a rising edge where in_valid and in_ready are both high; in_data is ignored otherwise.
REQ-014 SHALL contain a one-entry holding buffer and a 7-bit shift register; in_ready = holding buffer empty.
REQ-015 SHALL implement states IDLE, SHIFT, GAP.
REQ-016 IDLE: when the buffer is full, or a nibble is accepted this edge, SHALL load the shift register and enter SHIFT; an accept in IDLE passes straight to the shifter, leaving the buffer empty.
REQ-017 SHIFT: ser_valid high for exactly 7 cycles, ser_out = c[6]..c[0]; frame_start high on the first of these only.
REQ-018 After bit 0, SHALL enter GAP for IDLE_BITS cycles, or when IDLE_BITS=0 go directly to the next frame if the buffer is full, else to IDLE.
REQ-019 GAP end: buffer full -> SHIFT with the buffered word (buffer freed that edge); else IDLE.
REQ-020 Latency: a nibble accepted on edge N while IDLE SHALL drive frame_start and c[6] in cycle N+1.
REQ-021 With IDLE_BITS=0 and in_valid held high, frames SHALL be back-to-back: 7 ser_valid cycles per nibble, no bubbles.
REQ-022 Simultaneous buffer drain to the shifter and new accept on the same edge SHALL be legal; the buffer ends full with the new word.
REQ-023 code_out SHALL update only on shift-register load.

Reset
REQ-024 On rst_n low, SHALL immediately clear state to IDLE, empty the buffer, and drive ser_out=0, ser_valid=0, frame_start=0, code_out=0, busy=0, in_ready=0 while rst_n is low.
REQ-025 in_ready SHALL rise on the first clock edge after rst_n deasserts; a frame in progress at reset is discarded, with no partial-frame resume.

Configuration
REQ-026 Macro HAMMING_ERR_INJECT_EN SHALL, when defined, add inputs err_pos (3 bits), sampled with in_data; a nonzero value p flips codeword bit p-1 after encoding, and 0 means no flip.
REQ-027 Without HAMMING_ERR_INJECT_EN, err_pos SHALL not exist and every codeword SHALL be transmitted uncorrupted.

Verification
REQ-028 IDLE_BITS=1, accept 4'b1011 -> frame_start in the next cycle; serial 1,0,1,1,0,0,1; code_out=7'b1011001; then 1 idle cycle.
REQ-029 IDLE_BITS=0, in_valid held with nibbles 0001, 1111 -> frames 0001011 then 1111111 contiguous, 14 ser_valid cycles, and in_ready low only while the buffer is full.
REQ-030 Encode all 16 nibbles -> feed each codeword to the (7,4) corrector -> recovered nibble equals input and syndrome is 0.
REQ-031 With macro defined, accept 1011 and err_pos=5 -> transmitted 1001001; the corrector restores 1011.
REQ-032 Assert rst_n low at bit 3 of a frame with the buffer full -> outputs clear immediately; after release, no stale frame is emitted.

Source files
------------

// File: rtl/hamming_7_4_serial_encoder.sv
// hamming_7_4_serial_encoder: (7,4) Hamming encoder with one-word holding buffer and MSB-first serialiser.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_data      information nibble d[3:0], placed at codeword bits [6:3]
//   in_valid     in_data valid; a nibble is taken when in_valid & in_ready
//   err_pos      (HAMMING_ERR_INJECT_EN only) nonzero p flips codeword bit p-1
//   in_ready     holding buffer empty (and out of reset for at least one edge)
//   ser_out      serial codeword bit, bit 6 first
//   ser_valid    ser_out carries a codeword bit
//   frame_start  pulse with bit 6 of every frame
//   code_out     parallel copy of the frame being shifted, held until the next load
//   busy         frame shifting, gap running or holding buffer full
// Optional feature macro: HAMMING_ERR_INJECT_EN
module hamming_7_4_serial_encoder #(
    parameter int IDLE_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_data,
    input  logic       in_valid,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic [2:0] err_pos,
`endif
    output logic       in_ready,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       frame_start,
    output logic [6:0] code_out,
    output logic       busy
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
    localparam bit HAS_GAP = IDLE_BITS != 0;
    localparam logic [3:0] GAP_LAST = 4'(HAS_GAP ? IDLE_BITS - 1 : 0);
    state_t     r_state;
    state_t     w_state_n;
    logic [3:0] r_cnt;
    logic [6:0] r_buf;
    logic       r_buf_full;
    logic [6:0] r_shift;
    logic [6:0] r_code;
    logic       r_rdy_en;
    logic [6:0] w_clean;
    logic [6:0] w_code;
    logic       w_accept;
    logic       w_frame_end;
    logic       w_gap_end;
    logic       w_line_free;
    logic       w_load_buf;
    logic       w_load_direct;
    logic       w_load;
    logic       w_to_buf;
    logic [6:0] w_load_word;
    assign w_clean = {in_data,
                      in_data[3] ^ in_data[2] ^ in_data[1],
                      in_data[3] ^ in_data[2] ^ in_data[0],
                      in_data[3] ^ in_data[1] ^ in_data[0]};
`ifdef HAMMING_ERR_INJECT_EN
    assign w_code = w_clean ^ ((err_pos == 3'd0) ? 7'd0 : 7'd1 << (err_pos - 3'd1));
`else
    assign w_code = w_clean;
`endif
    assign w_accept      = in_valid & in_ready;
    assign w_frame_end   = (r_state == S_SHIFT) && (r_cnt == 4'd6);
    assign w_gap_end     = (r_state == S_GAP) && (r_cnt == GAP_LAST);
    // the shifter can take the next frame on this edge
    assign w_line_free   = (r_state == S_IDLE) || w_gap_end || (w_frame_end && !HAS_GAP);
    assign w_load_buf    = r_buf_full && w_line_free;
    // only an idle encoder lets an accepted nibble bypass the buffer
    assign w_load_direct = (r_state == S_IDLE) && !r_buf_full && w_accept;
    assign w_load        = w_load_buf | w_load_direct;
    assign w_to_buf      = w_accept & ~w_load_direct;
    assign w_load_word   = r_buf_full ? r_buf : w_code;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_n;
    end
    always_comb begin
        w_state_n = w_load      ? S_SHIFT :
                    w_frame_end ? (HAS_GAP ? S_GAP : S_IDLE) :
                    w_gap_end   ? S_IDLE : r_state;
    end
    always_comb begin
        in_ready    = r_rdy_en & ~r_buf_full;
        ser_valid   = r_state == S_SHIFT;
        ser_out     = ser_valid & r_shift[6];
        frame_start = ser_valid && (r_cnt == 4'd0);
        busy        = (r_state != S_IDLE) || r_buf_full;
        code_out    = r_code;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en   <= 1'b0;
            r_cnt      <= 4'd0;
            r_buf      <= 7'd0;
            r_buf_full <= 1'b0;
            r_shift    <= 7'd0;
            r_code     <= 7'd0;
        end else begin
            r_rdy_en   <= 1'b1;
            r_cnt      <= (w_load || w_state_n != r_state) ? 4'd0 : r_cnt + 4'd1;
            r_buf      <= w_to_buf ? w_code : r_buf;
            r_buf_full <= w_to_buf | (r_buf_full & ~w_load_buf);
            r_shift    <= w_load ? w_load_word :
                          (r_state == S_SHIFT) ? {r_shift[5:0], 1'b0} : r_shift;
            r_code     <= w_load ? w_load_word : r_code;
        end
    end
endmodule
